// File: rtl/issue_pkg.sv
// Shared constants and types for the reservation-station issue scheduler.
package issue_pkg;

   localparam int ISSUE_WIDTH     = 2;
   localparam int RS_SIZE_DEFAULT = 8;
   localparam int IDX_W_DEFAULT   = $clog2(RS_SIZE_DEFAULT);

   typedef logic [IDX_W_DEFAULT-1:0] rs_idx_t;

   typedef struct packed {
      logic    valid;
      rs_idx_t idx;
   } issue_gnt_t;

endpackage

// File: rtl/rr_pick_first.sv
// Round-robin first-set search: rotate so the start pointer sits at bit 0,
// take the lowest set bit, then add the pointer back to un-rotate.
module rr_pick_first #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] elig,
   input  logic [W-1:0] start,
   output logic         found,
   output logic [W-1:0] idx
);

   logic [N-1:0] rot;
   logic [W-1:0] off;

   always_comb begin
      rot   = N'({elig, elig} >> start);
      found = 1'b0;
      off   = '0;
      // Descending loop: the last hit written is the lowest set bit.
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            found = 1'b1;
            off   = W'(i);
         end
      end
      // N is a power of two, so the add wraps modulo N for free.
      idx = start + off;
   end

endmodule

// File: rtl/rs_issue_sched.sv
// Dual-issue round-robin scheduler for the RS, with occupancy tracking for
// the single non-pipelined multiplier.
module rs_issue_sched
   import issue_pkg::*;
#(
   parameter int RS_SIZE  = RS_SIZE_DEFAULT,
   parameter int MULT_LAT = 4,
   parameter int IDX_W    = $clog2(RS_SIZE)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [RS_SIZE-1:0]     req,
   input  logic [RS_SIZE-1:0]     is_mult,
   input  logic [ISSUE_WIDTH-1:0] port_ready,
   input  logic                   stall,
   input  logic                   flush,
   output logic [ISSUE_WIDTH-1:0] gnt_valid,
   output logic [IDX_W-1:0]       gnt_idx0,
   output logic [IDX_W-1:0]       gnt_idx1,
   output logic [RS_SIZE-1:0]     gnt_mask,
   output logic                   mult_busy,
   output logic [IDX_W-1:0]       rr_ptr
);

   localparam int CNT_W = $clog2(MULT_LAT + 1);
   localparam logic [RS_SIZE-1:0] ONE = {{(RS_SIZE-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0]   mult_cnt;
   logic [RS_SIZE-1:0] elig0, elig1, pick0_oh;
   logic               found0, found1, first_mult;
   logic [IDX_W-1:0]   pick0, pick1, last_idx;
   logic               take0, take1, mult_gnt;

   assign mult_busy = (mult_cnt != '0);
   assign elig0     = req & ~(is_mult & {RS_SIZE{mult_busy}});

   rr_pick_first #(.N(RS_SIZE), .W(IDX_W)) u_pick0 (
      .elig  (elig0),
      .start (rr_ptr),
      .found (found0),
      .idx   (pick0)
   );

   // Second pick never repeats the first, and skips every mult entry once
   // the first pick already claimed the multiplier.
   assign pick0_oh   = found0 ? (ONE << pick0) : '0;
   assign first_mult = found0 && is_mult[pick0];
   assign elig1      = elig0 & ~pick0_oh & ~(first_mult ? is_mult : '0);

   rr_pick_first #(.N(RS_SIZE), .W(IDX_W)) u_pick1 (
      .elig  (elig1),
      .start (rr_ptr),
      .found (found1),
      .idx   (pick1)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves one unassigned, which would otherwise infer a latch.
      gnt_valid = '0;
      gnt_idx0  = '0;
      gnt_idx1  = '0;
      gnt_mask  = '0;
      take0     = 1'b0;
      take1     = 1'b0;
      if (!stall && !flush) begin
         take0 = found0 && (|port_ready);
         take1 = found1 && (&port_ready);
      end
      if (take0) begin
         // With only port 1 ready, the first pick lands there.
         if (port_ready[0]) begin
            gnt_valid[0] = 1'b1;
            gnt_idx0     = pick0;
         end else begin
            gnt_valid[1] = 1'b1;
            gnt_idx1     = pick0;
         end
         gnt_mask = gnt_mask | (ONE << pick0);
      end
      if (take1) begin
         gnt_valid[1] = 1'b1;
         gnt_idx1     = pick1;
         gnt_mask     = gnt_mask | (ONE << pick1);
      end
      mult_gnt = (take0 && is_mult[pick0]) || (take1 && is_mult[pick1]);
      last_idx = take1 ? pick1 : pick0;
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr   <= '0;
         mult_cnt <= '0;
      end else begin
         if (flush)
            rr_ptr <= '0;
         else if (take0)
            rr_ptr <= last_idx + 1'b1;

         // Flush leaves the counter alone so an in-flight multiply drains.
         if (mult_gnt)
            mult_cnt <= CNT_W'(MULT_LAT - 1);
         else if (mult_cnt != '0)
            mult_cnt <= mult_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed self-checking bench for rs_issue_sched (RS_SIZE=8, MULT_LAT=4).
module tb_rs_issue_sched;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] req, is_mult;
   logic [1:0] port_ready;
   logic       stall, flush;
   logic [1:0] gnt_valid;
   logic [2:0] gnt_idx0, gnt_idx1;
   logic [7:0] gnt_mask;
   logic       mult_busy;
   logic [2:0] rr_ptr;

   int n_checks = 0;
   int n_fails  = 0;
   logic [7:0] seen;

   rs_issue_sched #(.RS_SIZE(8), .MULT_LAT(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .req        (req),
      .is_mult    (is_mult),
      .port_ready (port_ready),
      .stall      (stall),
      .flush      (flush),
      .gnt_valid  (gnt_valid),
      .gnt_idx0   (gnt_idx0),
      .gnt_idx1   (gnt_idx1),
      .gnt_mask   (gnt_mask),
      .mult_busy  (mult_busy),
      .rr_ptr     (rr_ptr)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Apply inputs just after the falling edge and let them settle.
   task automatic drive(input logic [7:0] r, input logic [7:0] m, input logic [1:0] p,
                        input logic s, input logic f);
      @(negedge clock);
      req = r; is_mult = m; port_ready = p; stall = s; flush = f;
      #1;
   endtask

   task automatic grants(input string tag, input logic [1:0] v, input logic [2:0] i0,
                         input logic [2:0] i1, input logic [7:0] mk);
      check({tag, ".valid"}, 32'(gnt_valid), 32'(v));
      check({tag, ".idx0"},  32'(gnt_idx0),  32'(i0));
      check({tag, ".idx1"},  32'(gnt_idx1),  32'(i1));
      check({tag, ".mask"},  32'(gnt_mask),  32'(mk));
   endtask

   // Step past the next rising edge and check the registered state.
   task automatic state(input string tag, input logic [2:0] ptr, input logic busy);
      @(posedge clock);
      #1;
      check({tag, ".rr_ptr"},    32'(rr_ptr),    32'(ptr));
      check({tag, ".mult_busy"}, 32'(mult_busy), 32'(busy));
   endtask

   initial begin
      reset = 1'b1; req = '0; is_mult = '0; port_ready = 2'b11; stall = 1'b0; flush = 1'b0;
      #12;
      check("reset.rr_ptr", 32'(rr_ptr), 32'd0);
      check("reset.mult_busy", 32'(mult_busy), 32'd0);
      grants("reset", 2'b00, 3'd0, 3'd0, 8'h00);
      @(negedge clock);
      reset = 1'b0;

      // Basic dual issue, then wrap-around from pointer 6.
      drive(8'b0010_0100, 8'h00, 2'b11, 1'b0, 1'b0);
      grants("dual", 2'b11, 3'd2, 3'd5, 8'h24);
      state("dual", 3'd6, 1'b0);
      drive(8'b1000_0001, 8'h00, 2'b11, 1'b0, 1'b0);
      grants("wrap", 2'b11, 3'd7, 3'd0, 8'h81);
      state("wrap", 3'd1, 1'b0);

      // Flush suppresses grants and returns the pointer to 0.
      drive(8'hFF, 8'h00, 2'b11, 1'b0, 1'b1);
      grants("flush0", 2'b00, 3'd0, 3'd0, 8'h00);
      state("flush0", 3'd0, 1'b0);

      // Two mult entries: only one may go, second mult is skipped.
      drive(8'h03, 8'h03, 2'b11, 1'b0, 1'b0);
      grants("mult_t", 2'b01, 3'd0, 3'd0, 8'h01);
      state("mult_t", 3'd1, 1'b1);
      drive(8'h06, 8'h02, 2'b11, 1'b0, 1'b0);
      grants("mult_t1", 2'b01, 3'd2, 3'd0, 8'h04);
      state("mult_t1", 3'd3, 1'b1);
      drive(8'h02, 8'h02, 2'b11, 1'b0, 1'b0);
      grants("mult_t2", 2'b00, 3'd0, 3'd0, 8'h00);
      state("mult_t2", 3'd3, 1'b1);
      drive(8'h02, 8'h02, 2'b11, 1'b0, 1'b0);
      grants("mult_t3", 2'b00, 3'd0, 3'd0, 8'h00);
      state("mult_t3", 3'd3, 1'b0);
      drive(8'h02, 8'h02, 2'b11, 1'b0, 1'b0);
      grants("mult_t4", 2'b01, 3'd1, 3'd0, 8'h02);
      state("mult_t4", 3'd2, 1'b1);

      // Flush mid-multiply: pointer resets, counter keeps draining (3 -> 2).
      drive(8'hFF, 8'h00, 2'b11, 1'b0, 1'b1);
      grants("flush1", 2'b00, 3'd0, 3'd0, 8'h00);
      state("flush1", 3'd0, 1'b1);

      // Only port 1 ready: first pick goes there, port 0 idle (counter 2 -> 1).
      drive(8'b0001_1000, 8'h00, 2'b10, 1'b0, 1'b0);
      grants("port1", 2'b10, 3'd0, 3'd3, 8'h08);
      state("port1", 3'd4, 1'b1);

      // Neither port ready: nothing issues, pointer holds (counter 1 -> 0).
      drive(8'hFF, 8'h00, 2'b00, 1'b0, 1'b0);
      grants("noport", 2'b00, 3'd0, 3'd0, 8'h00);
      state("noport", 3'd4, 1'b0);

      // Stall with everything ready: no grants, pointer holds.
      drive(8'hFF, 8'h00, 2'b11, 1'b1, 1'b0);
      grants("stall", 2'b00, 3'd0, 3'd0, 8'h00);
      state("stall", 3'd4, 1'b0);

      // Mult grant at pointer 4, then flush from pointer 5 while it drains.
      drive(8'h10, 8'h10, 2'b11, 1'b0, 1'b0);
      grants("mult4", 2'b01, 3'd4, 3'd0, 8'h10);
      state("mult4", 3'd5, 1'b1);
      drive(8'hFF, 8'h00, 2'b11, 1'b0, 1'b1);
      grants("flush5", 2'b00, 3'd0, 3'd0, 8'h00);
      state("flush5", 3'd0, 1'b1);
      drive(8'h00, 8'h00, 2'b11, 1'b0, 1'b0);
      state("drain1", 3'd0, 1'b1);
      drive(8'h00, 8'h00, 2'b11, 1'b0, 1'b0);
      state("drain0", 3'd0, 1'b0);

      // Mult first pick with a non-mult second pick; reach rr_ptr=3, mult_cnt=2.
      drive(8'h07, 8'h01, 2'b11, 1'b0, 1'b0);
      grants("mixed", 2'b11, 3'd0, 3'd1, 8'h03);
      state("mixed", 3'd2, 1'b1);
      drive(8'h04, 8'h00, 2'b11, 1'b0, 1'b0);
      grants("pre_rst", 2'b01, 3'd2, 3'd0, 8'h04);
      state("pre_rst", 3'd3, 1'b1);

      // Async reset between edges clears state at once.
      drive(8'hFF, 8'h00, 2'b11, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      check("async.rr_ptr", 32'(rr_ptr), 32'd0);
      check("async.mult_busy", 32'(mult_busy), 32'd0);
      grants("async", 2'b11, 3'd0, 3'd1, 8'h03);
      #1;
      reset = 1'b0;

      // Fairness: all-ready for 4 cycles issues 0-1, 2-3, 4-5, 6-7 exactly once.
      seen = '0;
      for (int k = 0; k < 4; k++) begin
         if (k != 0) drive(8'hFF, 8'h00, 2'b11, 1'b0, 1'b0);
         check("fair.idx0", 32'(gnt_idx0), 32'(2 * k));
         check("fair.idx1", 32'(gnt_idx1), 32'(2 * k + 1));
         check("fair.overlap", 32'(seen & gnt_mask), 32'd0);
         seen = seen | gnt_mask;
         @(posedge clock);
         #1;
      end
      check("fair.all", 32'(seen), 32'h0000_00FF);
      check("fair.rr_ptr", 32'(rr_ptr), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
